// File: rtl/sram_arb_pkg.sv
// Shared types, widths and the round-robin step helper for the frame-buffer
// SRAM arbiter.
package sram_arb_pkg;

  localparam int unsigned WAIT_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    TURN   = 2'd2
  } state_t;

  // Next channel index after idx, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin channel selector with optional channel-0 priority.
// The search starts one past the last granted channel held in pointer.
module rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter bit          PRIO_CH0 = 1'b1,
  parameter int unsigned IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  pointer,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx
);

  always_comb begin
    int unsigned idx;
    grant     = '0;
    grant_idx = '0;
    idx       = 32'(pointer);
    for (int i = 0; i < int'(NUM_CH); i++) begin
      idx = rr_next(idx, NUM_CH);
      if (grant == '0 && req[IDX_W'(idx)]) begin
        grant[IDX_W'(idx)] = 1'b1;
        grant_idx          = IDX_W'(idx);
      end
    end
    // Channel 0 (display fetch) overrides the rotation when enabled.
    if (PRIO_CH0 && req[0]) begin
      grant     = NUM_CH'(1);
      grant_idx = '0;
    end
  end

endmodule

// File: rtl/frame_buffer_sram_arbiter.sv
// Multi-channel arbiter and strobe sequencer for the asynchronous frame-buffer
// SRAM: round-robin grant, wait-stated reads/writes, read-to-write turnaround.
module frame_buffer_sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned AW         = 20,
  parameter int unsigned DW         = 16,
  parameter int unsigned READ_WAIT  = 1,
  parameter int unsigned WRITE_WAIT = 1,
  parameter bit          PRIO_CH0   = 1'b1
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_write,
  input  logic [NUM_CH*AW-1:0]     ch_addr,
  input  logic [NUM_CH*DW-1:0]     ch_wdata,
  input  logic [NUM_CH*DW/8-1:0]   ch_be,
  output logic [NUM_CH-1:0]        ch_ready,
  output logic [NUM_CH-1:0]        ch_rvalid,
  output logic [DW-1:0]            ch_rdata,
  output logic [AW-1:0]            sram_addr,
  inout  wire  [DW-1:0]            sram_dq,
  output logic                     sram_ce_n,
  output logic                     sram_oe_n,
  output logic                     sram_we_n,
  output logic [DW/8-1:0]          sram_be_n
);

  localparam int unsigned BE_W  = DW / 8;
  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_t              state, state_nxt;
  logic [WAIT_W-1:0]   cnt, cnt_nxt;
  logic [IDX_W-1:0]    ptr, op_ch, grant_idx;
  logic [NUM_CH-1:0]   grant;
  logic                op_write, last_rd, dq_oe;
  logic [DW-1:0]       wdata_q;
  logic [BE_W-1:0]     be_q;

  logic                sel_write;
  logic [AW-1:0]       sel_addr;
  logic [DW-1:0]       sel_wdata;
  logic [BE_W-1:0]     sel_be;
  logic                start, acc_nxt, wr_nxt, done;
  logic [BE_W-1:0]     be_nxt;

  rr_arbiter #(
    .NUM_CH   (NUM_CH),
    .PRIO_CH0 (PRIO_CH0),
    .IDX_W    (IDX_W)
  ) u_rr_arbiter (
    .req       (ch_req),
    .pointer   (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // One-hot mux of the granted channel's request payload.
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (grant[i]) begin
        sel_write = ch_write[i];
        sel_addr  = ch_addr[i*AW +: AW];
        sel_wdata = ch_wdata[i*DW +: DW];
        sel_be    = ch_be[i*BE_W +: BE_W];
      end
    end
  end

  assign start    = (state == IDLE) && (|ch_req);
  assign done     = (state == ACCESS) && (cnt == '0);
  assign ch_ready = (start && !sys_rst) ? grant : '0;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (sel_write && last_rd) ? TURN : ACCESS;
          cnt_nxt   = sel_write ? WAIT_W'(WRITE_WAIT) : WAIT_W'(READ_WAIT);
        end
      end
      TURN:    state_nxt = ACCESS;
      ACCESS: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they track ACCESS exactly.
  assign acc_nxt = (state_nxt == ACCESS);
  assign wr_nxt  = start ? sel_write : op_write;
  assign be_nxt  = start ? sel_be : be_q;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= IDX_W'(NUM_CH - 1);
      op_ch     <= '0;
      op_write  <= 1'b1;
      last_rd   <= 1'b0;
      wdata_q   <= '0;
      be_q      <= '0;
      sram_addr <= '0;
      ch_rvalid <= '0;
      ch_rdata  <= '0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_be_n <= '1;
      dq_oe     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ch_rvalid <= '0;
      if (start) begin
        ptr       <= grant_idx;
        op_ch     <= grant_idx;
        op_write  <= sel_write;
        sram_addr <= sel_addr;
        wdata_q   <= sel_wdata;
        be_q      <= sel_be;
      end
      if (done) begin
        last_rd <= !op_write;
        if (!op_write) begin
          ch_rvalid[op_ch] <= 1'b1;
          ch_rdata         <= sram_dq;
        end
      end
      sram_ce_n <= !acc_nxt;
      sram_oe_n <= !(acc_nxt && !wr_nxt);
      sram_we_n <= !(acc_nxt && wr_nxt);
      sram_be_n <= acc_nxt ? (wr_nxt ? ~be_nxt : '0) : '1;
      dq_oe     <= acc_nxt && wr_nxt;
    end
  end

  assign sram_dq = dq_oe ? wdata_q : {DW{1'bz}};

endmodule
